// File: rtl/calc_engine.sv
// Four-function decimal calculator engine.
// Operands are entered as BCD digit keys, converted to binary (Horner),
// combined (add/sub/mul in one cycle, restoring division over BIN_W cycles),
// and converted back to BCD (double dabble) for display.
// Ports:
//   clock, reset_n                  clock and asynchronous active-low reset
//   dig_strobe/dig_code             digit key (codes 10-15 ignored)
//   op_strobe/op_code               operator key: 00 add, 01 sub, 10 mul, 11 div
//   ex/clr/bksp/ms/mr/mc_strobe     execute, clear, backspace, memory keys
//   disp_bcd, disp_neg, disp_sel    display value, sign and source
//   busy, err, mem_valid            status
module calc_engine #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 20
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  dig_strobe,
  input  logic [3:0]            dig_code,
  input  logic                  op_strobe,
  input  logic [1:0]            op_code,
  input  logic                  ex_strobe,
  input  logic                  clr_strobe,
  input  logic                  bksp_strobe,
  input  logic                  ms_strobe,
  input  logic                  mr_strobe,
  input  logic                  mc_strobe,
  output logic [4*2*DIGITS-1:0] disp_bcd,
  output logic                  disp_neg,
  output logic [1:0]            disp_sel,
  output logic                  busy,
  output logic                  err,
  output logic                  mem_valid
);

  localparam int unsigned OPD_W  = 4 * DIGITS;
  localparam int unsigned RES_W  = 8 * DIGITS;
  localparam int unsigned DCNT_W = $clog2(DIGITS + 1);
  localparam int unsigned STEP_W = $clog2(BIN_W + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_ENTER_A, S_ENTER_B, S_CONVERT, S_COMPUTE, S_FORMAT, S_RESULT, S_ERROR
  } state_t;

  state_t state, next_state;

  logic [OPD_W-1:0]  a_bcd, b_bcd, a_bcd_d, b_bcd_d;
  logic [DCNT_W-1:0] a_cnt, b_cnt, a_cnt_d, b_cnt_d;
  logic [1:0]        op_q, op_d;
  logic [BIN_W-1:0]  a_bin, b_bin, a_bin_d, b_bin_d;
  logic [BIN_W-1:0]  rem, rem_d;
  logic [BIN_W-1:0]  res_bin, res_bin_d;
  logic [RES_W-1:0]  res_bcd, res_bcd_d;
  logic              res_neg, res_neg_d;
  logic [RES_W-1:0]  mem_bcd, mem_bcd_d;
  logic              mem_neg, mem_neg_d;
  logic              mem_valid_d;
  logic [STEP_W-1:0] step, step_d;

  logic [RES_W-1:0]  disp_bcd_d;
  logic              disp_neg_d, busy_d, err_d;
  logic [1:0]        disp_sel_d;

  logic idle, dig_ok, sel_b;
  logic act_clr, act_ex, act_op, act_dig, act_bksp, act_mr, act_ms, act_mc;

  // Strobe arbitration: only the highest-priority pulse acts; busy blocks all but clear.
  assign idle   = !(state inside {S_CONVERT, S_COMPUTE, S_FORMAT});
  assign dig_ok = (dig_code <= 4'd9);
  assign sel_b  = (state == S_ENTER_B);

  always_comb begin
    act_clr  = clr_strobe;
    act_ex   = idle && !clr_strobe && ex_strobe;
    act_op   = idle && !clr_strobe && !ex_strobe && op_strobe;
    act_dig  = idle && !clr_strobe && !ex_strobe && !op_strobe && dig_strobe;
    act_bksp = idle && !clr_strobe && !ex_strobe && !op_strobe && !dig_strobe && bksp_strobe;
    act_mr   = idle && !clr_strobe && !ex_strobe && !op_strobe && !dig_strobe && !bksp_strobe
               && mr_strobe;
    act_ms   = idle && !clr_strobe && !ex_strobe && !op_strobe && !dig_strobe && !bksp_strobe
               && !mr_strobe && ms_strobe;
    act_mc   = idle && !clr_strobe && !ex_strobe && !op_strobe && !dig_strobe && !bksp_strobe
               && !mr_strobe && !ms_strobe && mc_strobe;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_ENTER_A;
    else          state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    if (act_clr) begin
      next_state = S_ENTER_A;
    end else begin
      case (state)
        S_ENTER_A: if (act_op) next_state = S_ENTER_B;
        S_ENTER_B: if (act_ex) next_state = S_CONVERT;
        S_CONVERT: if (step == STEP_W'(DIGITS - 1)) next_state = S_COMPUTE;
        S_COMPUTE: begin
          if (op_q != OP_DIV)                     next_state = S_FORMAT;
          else if (b_bin == '0)                   next_state = S_ERROR;
          else if (step == STEP_W'(BIN_W - 1))    next_state = S_FORMAT;
        end
        S_FORMAT:  if (step == STEP_W'(BIN_W - 1)) next_state = S_RESULT;
        S_RESULT:  if (act_dig && dig_ok) next_state = S_ENTER_A;
        default:   ;
      endcase
    end
  end

  // Datapath next values.
  logic [OPD_W-1:0]  cur_bcd, nxt_bcd;
  logic [DCNT_W-1:0] cur_cnt, nxt_cnt, sig_cnt;
  logic              edit, mr_ok;
  logic [BIN_W:0]    rem_sh;
  logic [BIN_W-1:0]  q_sh;
  logic [RES_W-1:0]  dd_adj;

  always_comb begin
    a_bcd_d = a_bcd;  b_bcd_d = b_bcd;  a_cnt_d = a_cnt;  b_cnt_d = b_cnt;
    op_d = op_q;  a_bin_d = a_bin;  b_bin_d = b_bin;  rem_d = rem;
    res_bin_d = res_bin;  res_bcd_d = res_bcd;  res_neg_d = res_neg;
    mem_bcd_d = mem_bcd;  mem_neg_d = mem_neg;  mem_valid_d = mem_valid;
    step_d  = (!idle && next_state == state) ? step + STEP_W'(1) : '0;
    cur_bcd = sel_b ? b_bcd : a_bcd;
    cur_cnt = sel_b ? b_cnt : a_cnt;
    nxt_bcd = cur_bcd;
    nxt_cnt = cur_cnt;
    edit    = 1'b0;
    rem_sh  = {rem, a_bin[BIN_W-1]};
    q_sh    = a_bin << 1;
    sig_cnt = '0;
    for (int i = 0; i < int'(DIGITS); i++)
      if (mem_bcd[4*i +: 4] != 4'd0) sig_cnt = DCNT_W'(i + 1);
    mr_ok   = mem_valid && !mem_neg && (mem_bcd[RES_W-1:OPD_W] == '0);
    for (int i = 0; i < int'(2 * DIGITS); i++)
      dd_adj[4*i +: 4] = (res_bcd[4*i +: 4] >= 4'd5) ? res_bcd[4*i +: 4] + 4'd3
                                                      : res_bcd[4*i +: 4];

    if (act_clr) begin
      a_bcd_d = '0;  b_bcd_d = '0;  a_cnt_d = '0;  b_cnt_d = '0;  op_d = OP_ADD;
    end else begin
      case (state)
        S_ENTER_A, S_ENTER_B: begin
          if (act_ex) begin
            if (sel_b) begin
              // Horner accumulators and the dabble register must start from zero.
              a_bin_d = '0;  b_bin_d = '0;  rem_d = '0;
              res_bcd_d = '0;  res_neg_d = 1'b0;
            end
          end else if (act_op) begin
            op_d = op_code;
          end else if (act_dig) begin
            // A leading zero into an empty operand leaves it empty.
            if (dig_ok && cur_cnt != DCNT_W'(DIGITS) && !(cur_cnt == '0 && dig_code == 4'd0)) begin
              nxt_bcd = (cur_bcd << 4) | OPD_W'(dig_code);
              nxt_cnt = cur_cnt + DCNT_W'(1);
              edit    = 1'b1;
            end
          end else if (act_bksp) begin
            if (cur_cnt != '0) begin
              nxt_bcd = cur_bcd >> 4;
              nxt_cnt = cur_cnt - DCNT_W'(1);
              edit    = 1'b1;
            end
          end else if (act_mr) begin
            if (mr_ok) begin
              nxt_bcd = mem_bcd[OPD_W-1:0];
              nxt_cnt = sig_cnt;
              edit    = 1'b1;
            end
          end else if (act_mc) begin
            mem_bcd_d = '0;  mem_neg_d = 1'b0;  mem_valid_d = 1'b0;
          end
        end
        S_CONVERT: begin
          // Consume the most significant nibble each cycle: bin = bin*10 + digit.
          a_bin_d = (a_bin << 3) + (a_bin << 1) + BIN_W'(a_bcd[OPD_W-1 -: 4]);
          b_bin_d = (b_bin << 3) + (b_bin << 1) + BIN_W'(b_bcd[OPD_W-1 -: 4]);
          a_bcd_d = a_bcd << 4;
          b_bcd_d = b_bcd << 4;
        end
        S_COMPUTE: begin
          case (op_q)
            OP_ADD: res_bin_d = a_bin + b_bin;
            OP_SUB: begin
              if (a_bin >= b_bin) res_bin_d = a_bin - b_bin;
              else begin
                res_bin_d = b_bin - a_bin;
                res_neg_d = 1'b1;
              end
            end
            OP_MUL: res_bin_d = a_bin * b_bin;
            default: begin
              // Restoring division: a_bin shifts out the dividend and collects the quotient.
              if (b_bin != '0) begin
                if (rem_sh >= {1'b0, b_bin}) begin
                  rem_d   = BIN_W'(rem_sh - {1'b0, b_bin});
                  q_sh[0] = 1'b1;
                end else begin
                  rem_d = rem_sh[BIN_W-1:0];
                end
                a_bin_d = q_sh;
                if (step == STEP_W'(BIN_W - 1)) res_bin_d = q_sh;
              end
            end
          endcase
        end
        S_FORMAT: begin
          res_bcd_d = RES_W'({dd_adj, res_bin[BIN_W-1]});
          res_bin_d = res_bin << 1;
        end
        S_RESULT: begin
          if (act_dig) begin
            if (dig_ok) begin
              a_bcd_d = OPD_W'(dig_code);
              a_cnt_d = (dig_code != 4'd0) ? DCNT_W'(1) : '0;
              b_bcd_d = '0;  b_cnt_d = '0;  op_d = OP_ADD;
            end
          end else if (act_ms) begin
            mem_bcd_d = res_bcd;  mem_neg_d = res_neg;  mem_valid_d = 1'b1;
          end else if (act_mc) begin
            mem_bcd_d = '0;  mem_neg_d = 1'b0;  mem_valid_d = 1'b0;
          end
        end
        S_ERROR: begin
          if (act_mc) begin
            mem_bcd_d = '0;  mem_neg_d = 1'b0;  mem_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (edit) begin
      if (sel_b) begin b_bcd_d = nxt_bcd;  b_cnt_d = nxt_cnt; end
      else       begin a_bcd_d = nxt_bcd;  a_cnt_d = nxt_cnt; end
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_bcd <= '0;  b_bcd <= '0;  a_cnt <= '0;  b_cnt <= '0;  op_q <= OP_ADD;
      a_bin <= '0;  b_bin <= '0;  rem <= '0;  res_bin <= '0;
      res_bcd <= '0;  res_neg <= 1'b0;
      mem_bcd <= '0;  mem_neg <= 1'b0;  mem_valid <= 1'b0;
      step <= '0;
    end else begin
      a_bcd <= a_bcd_d;  b_bcd <= b_bcd_d;  a_cnt <= a_cnt_d;  b_cnt <= b_cnt_d;  op_q <= op_d;
      a_bin <= a_bin_d;  b_bin <= b_bin_d;  rem <= rem_d;  res_bin <= res_bin_d;
      res_bcd <= res_bcd_d;  res_neg <= res_neg_d;
      mem_bcd <= mem_bcd_d;  mem_neg <= mem_neg_d;  mem_valid <= mem_valid_d;
      step <= step_d;
    end
  end

  // Output logic, decoded from the state being entered so outputs align with it.
  always_comb begin
    disp_bcd_d = disp_bcd;
    disp_neg_d = disp_neg;
    disp_sel_d = disp_sel;
    busy_d     = next_state inside {S_CONVERT, S_COMPUTE, S_FORMAT};
    err_d      = (next_state == S_ERROR);
    case (next_state)
      S_ENTER_A: begin disp_bcd_d = RES_W'(a_bcd_d); disp_neg_d = 1'b0;      disp_sel_d = 2'b00; end
      S_ENTER_B: begin disp_bcd_d = RES_W'(b_bcd_d); disp_neg_d = 1'b0;      disp_sel_d = 2'b01; end
      S_RESULT:  begin disp_bcd_d = res_bcd_d;       disp_neg_d = res_neg_d; disp_sel_d = 2'b10; end
      S_ERROR:   begin disp_bcd_d = '0;              disp_neg_d = 1'b0;      disp_sel_d = 2'b11; end
      default:   ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp_bcd <= '0;  disp_neg <= 1'b0;  disp_sel <= 2'b00;  busy <= 1'b0;  err <= 1'b0;
    end else begin
      disp_bcd <= disp_bcd_d;  disp_neg <= disp_neg_d;  disp_sel <= disp_sel_d;
      busy <= busy_d;  err <= err_d;
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
`timescale 1ns/1ps
module tb_calc_engine;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 20;
  localparam int unsigned RES_W  = 8 * DIGITS;

  // Strobe mask bits, highest priority in the top bit.
  localparam int K_CLR = 7, K_EX = 6, K_OP = 5, K_DIG = 4, K_BKSP = 3, K_MR = 2, K_MS = 1, K_MC = 0;
  localparam logic [7:0] M_DIG = 8'h10, M_OP = 8'h20, M_BKSP = 8'h08, M_CLR = 8'h80;
  localparam int ST_A = 0, ST_B = 1, ST_RES = 2, ST_ERR = 3;

  logic clock = 1'b0, reset_n = 1'b0;
  logic dig_strobe = 0, op_strobe = 0, ex_strobe = 0, clr_strobe = 0;
  logic bksp_strobe = 0, ms_strobe = 0, mr_strobe = 0, mc_strobe = 0;
  logic [3:0] dig_code = 0;
  logic [1:0] op_code = 0;
  logic [RES_W-1:0] disp_bcd;
  logic disp_neg, busy, err, mem_valid;
  logic [1:0] disp_sel;

  calc_engine #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .dig_strobe(dig_strobe), .dig_code(dig_code), .op_strobe(op_strobe), .op_code(op_code),
    .ex_strobe(ex_strobe), .clr_strobe(clr_strobe), .bksp_strobe(bksp_strobe),
    .ms_strobe(ms_strobe), .mr_strobe(mr_strobe), .mc_strobe(mc_strobe),
    .disp_bcd(disp_bcd), .disp_neg(disp_neg), .disp_sel(disp_sel),
    .busy(busy), .err(err), .mem_valid(mem_valid)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0, last_busy = 0;

  // Reference model: operands and results are plain integers.
  int m_st, m_a, m_b, m_op, m_res, m_rneg, m_mem, m_mneg, m_mvalid, m_pend, m_exp_busy;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] to_bcd(input int v);
    logic [RES_W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < int'(2 * DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_st = ST_A; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_rneg = 0;
    m_mem = 0; m_mneg = 0; m_mvalid = 0; m_pend = 0; m_exp_busy = 0;
  endtask

  task automatic model_exec();
    m_pend = 1; m_rneg = 0; m_st = ST_RES;
    m_exp_busy = DIGITS + 1 + BIN_W;
    case (m_op)
      0: m_res = m_a + m_b;
      1: if (m_a >= m_b) m_res = m_a - m_b; else begin m_res = m_b - m_a; m_rneg = 1; end
      2: m_res = m_a * m_b;
      default: begin
        if (m_b == 0) begin m_st = ST_ERR; m_exp_busy = DIGITS + 1; end
        else begin m_res = m_a / m_b; m_exp_busy = DIGITS + 2 * BIN_W; end
      end
    endcase
  endtask

  task automatic model_apply(input logic [7:0] mask, input int code);
    int cur;
    bit entry;
    entry = (m_st == ST_A || m_st == ST_B);
    cur = (m_st == ST_B) ? m_b : m_a;
    if (mask[K_CLR]) begin m_a = 0; m_b = 0; m_op = 0; m_st = ST_A; return; end
    if (mask[K_EX]) begin if (m_st == ST_B) model_exec(); return; end
    if (mask[K_OP]) begin if (entry) begin m_op = code % 4; m_st = ST_B; end return; end
    if (mask[K_DIG]) begin
      if (code <= 9) begin
        if (entry && cur < 10 ** (DIGITS - 1)) cur = cur * 10 + code;
        else if (m_st == ST_RES) begin m_a = code; m_b = 0; m_st = ST_A; return; end
      end
    end else if (mask[K_BKSP]) begin
      if (entry) cur = cur / 10;
    end else if (mask[K_MR]) begin
      if (entry && m_mvalid != 0 && m_mneg == 0 && m_mem < 10 ** DIGITS) cur = m_mem;
    end else if (mask[K_MS]) begin
      if (m_st == ST_RES) begin m_mem = m_res; m_mneg = m_rneg; m_mvalid = 1; end
    end else if (mask[K_MC]) begin
      m_mem = 0; m_mneg = 0; m_mvalid = 0;
    end
    if (m_st == ST_A) m_a = cur;
    else if (m_st == ST_B) m_b = cur;
  endtask

  task automatic check_outputs(input string tag);
    int ev, en;
    ev = (m_st == ST_A) ? m_a : (m_st == ST_B) ? m_b : (m_st == ST_RES) ? m_res : 0;
    en = (m_st == ST_RES) ? m_rneg : 0;
    check({tag, " disp_bcd"}, int'(disp_bcd), int'(to_bcd(ev)));
    check({tag, " disp_neg"}, int'(disp_neg), en);
    check({tag, " disp_sel"}, int'(disp_sel), m_st);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " err"}, int'(err), (m_st == ST_ERR) ? 1 : 0);
    check({tag, " mem_valid"}, int'(mem_valid), m_mvalid);
  endtask

  // One key cycle; waits out any computation the key starts.
  task automatic press(input logic [7:0] mask, input int code, input string tag);
    int cnt;
    @(negedge clock);
    clr_strobe = mask[K_CLR]; ex_strobe = mask[K_EX]; op_strobe = mask[K_OP];
    dig_strobe = mask[K_DIG]; bksp_strobe = mask[K_BKSP]; mr_strobe = mask[K_MR];
    ms_strobe = mask[K_MS]; mc_strobe = mask[K_MC];
    dig_code = 4'(code); op_code = 2'(code);
    model_apply(mask, code);
    @(negedge clock);
    {clr_strobe, ex_strobe, op_strobe, dig_strobe, bksp_strobe, mr_strobe, ms_strobe, mc_strobe} = '0;
    if (m_pend != 0) begin
      m_pend = 0;
      cnt = 0;
      for (int w = 0; w < 2 && !busy; w++) @(negedge clock);
      check({tag, " held disp_sel"}, int'(disp_sel), ST_B);
      while (busy && cnt < 500) begin cnt++; @(negedge clock); end
      last_busy = cnt;
      check({tag, " busy_cycles"}, cnt, m_exp_busy);
    end
    check_outputs(tag);
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      case (c)
        "+": press(8'h20, 0, s);
        "-": press(8'h20, 1, s);
        "*": press(8'h20, 2, s);
        "/": press(8'h20, 3, s);
        "=": press(8'h40, 0, s);
        "c": press(8'h80, 0, s);
        "b": press(8'h08, 0, s);
        "r": press(8'h04, 0, s);
        "s": press(8'h02, 0, s);
        "m": press(8'h01, 0, s);
        default: press(8'h10, int'(c) - 48, s);
      endcase
    end
  endtask

  typedef struct { logic [7:0] mask; int code; int exp_val; int exp_sel; } vec_t;
  vec_t tbl [16];

  initial begin
    tbl[0]  = '{M_DIG, 1, 1, 0};     tbl[1]  = '{M_DIG, 2, 12, 0};
    tbl[2]  = '{M_DIG, 3, 123, 0};   tbl[3]  = '{M_DIG, 4, 123, 0};
    tbl[4]  = '{M_BKSP, 0, 12, 0};   tbl[5]  = '{M_BKSP, 0, 1, 0};
    tbl[6]  = '{M_BKSP, 0, 0, 0};    tbl[7]  = '{M_BKSP, 0, 0, 0};
    tbl[8]  = '{M_DIG, 0, 0, 0};     tbl[9]  = '{M_DIG, 5, 5, 0};
    tbl[10] = '{M_DIG, 0, 50, 0};    tbl[11] = '{M_OP, 0, 0, 1};
    tbl[12] = '{M_DIG, 7, 7, 1};     tbl[13] = '{M_DIG, 12, 7, 1};
    tbl[14] = '{M_DIG | M_BKSP, 3, 73, 1};
    tbl[15] = '{M_CLR | M_DIG, 9, 0, 0};

    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      press(tbl[i].mask, tbl[i].code, $sformatf("tbl[%0d]", i));
      check($sformatf("tbl[%0d] value", i), int'(disp_bcd), int'(to_bcd(tbl[i].exp_val)));
      check($sformatf("tbl[%0d] sel", i), int'(disp_sel), tbl[i].exp_sel);
    end

    keys("12+345=");
    check("add result", int'(disp_bcd), 'h357);
    check("add busy", last_busy, 24);
    check("add sel", int'(disp_sel), 2);
    keys("c5-12=");
    check("sub result", int'(disp_bcd), 'h7);
    check("sub neg", int'(disp_neg), 1);
    keys("c999*999=");
    check("mul result", int'(disp_bcd), 'h998001);
    keys("c100/7=");
    check("div result", int'(disp_bcd), 'h14);
    check("div busy", last_busy, 43);
    keys("c100/0=");
    check("div0 err", int'(err), 1);
    check("div0 sel", int'(disp_sel), 3);
    keys("5+bc");
    check("clr from error", int'(disp_sel), 0);
    keys("5=");
    check("ex in A ignored", int'(busy), 0);
    keys("c42+1=s");
    check("ms valid", int'(mem_valid), 1);
    keys("7+r");
    check("mr B", int'(disp_bcd), 'h43);
    keys("=");
    check("mr sum", int'(disp_bcd), 'h50);
    keys("c999*999=s1+r");
    check("mr big ignored", int'(disp_bcd), 0);
    keys("m");
    check("mc", int'(mem_valid), 0);

    // Reset in the middle of a division.
    keys("c100/7");
    @(negedge clock); ex_strobe = 1'b1;
    @(negedge clock); ex_strobe = 1'b0;
    repeat (8) @(negedge clock);
    check("div busy pre-reset", int'(busy), 1);
    #1 reset_n = 1'b0;
    model_reset();
    #1 check_outputs("mid reset");
    @(negedge clock); reset_n = 1'b1;
    keys("6/3=");
    check("post-reset div", int'(disp_bcd), 'h2);

    // Randomized key traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] mask;
      int code;
      r = $urandom_range(0, 99);
      code = $urandom_range(0, 11);
      if (r < 50)      mask = 8'h10;
      else if (r < 60) begin mask = 8'h20; code = $urandom_range(0, 3); end
      else if (r < 70) mask = 8'h40;
      else if (r < 78) mask = 8'h08;
      else if (r < 81) mask = 8'h80;
      else if (r < 84) mask = 8'h02;
      else if (r < 88) mask = 8'h04;
      else if (r < 90) mask = 8'h01;
      else             mask = 8'($urandom_range(1, 127));
      press(mask, code, $sformatf("rnd[%0d] m=%02h c=%0d", i, mask, code));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
- REQ-001: DIGITS, default 3; maximum operand length in decimal digits.
- REQ-002: BIN_W, default 20; internal binary width; SHALL satisfy 2^BIN_W > 10^(2*DIGITS).
- REQ-003: clock  in  1  system clock; all state changes on rising edge.
- REQ-004: reset_n  in  1  asynchronous, active-low reset.
- REQ-005: dig_strobe  in  1  one-cycle digit key pulse; dig_code in 4 carries digit 0-9, codes 10-15 ignored.
- REQ-006: op_strobe  in  1  one-cycle operator pulse; op_code in 2 selects 00 add, 01 sub, 10 mul, 11 div.
- REQ-007: ex_strobe, clr_strobe, bksp_strobe, ms_strobe, mr_strobe, mc_strobe  in  1 each  one-cycle pulses for execute, clear, backspace, memory store, recall and clear.
- REQ-008: disp_bcd  out  4*2*DIGITS  packed BCD display value; digit 0 in bits [3:0].
- REQ-009: disp_neg  out  1  displayed value is negative.
- REQ-010: disp_sel  out  2  00 operand A, 01 operand B, 10 result, 11 error.
- REQ-011: busy  out  1  high in CONVERT, COMPUTE and FORMAT.
- REQ-012: err  out  1  high in ERROR.
- REQ-013: mem_valid  out  1  memory register holds a stored value.

Function
- REQ-014: States: ENTER_A, ENTER_B, CONVERT, COMPUTE, FORMAT, RESULT, ERROR.
- REQ-015: Strobe priority when several are coincident: clr > ex > op > dig > bksp > mr > ms > mc; only the highest-priority strobe acts.
- REQ-016: clr_strobe in any state: clears A, B, digit counts and operator, enters ENTER_A next cycle; memory is kept.
- REQ-017: While busy, all strobes except clr_strobe are ignored.
- REQ-018: Digit entry: the digit shifts into the least significant nibble of the active operand. Entry is ignored when the operand already holds DIGITS digits. A leading zero entered into an empty operand does not increment its count.
- REQ-019: bksp_strobe: shifts the active operand right one nibble and decrements its count; no-op when the count is 0.
- REQ-020: ENTER_A + op_strobe: latch op_code, go to ENTER_B. ENTER_B + op_strobe: replace the latched operator, stay in ENTER_B.
- REQ-021: ex_strobe: acts only in ENTER_B and goes to CONVERT; ignored in every other state.
- REQ-022: CONVERT: converts A and B BCD-to-binary in parallel, Horner form, most significant digit first; exactly DIGITS cycles.
- REQ-023: COMPUTE: add/sub/mul complete in 1 cycle. div is restoring division of BIN_W cycles; the integer quotient is kept and the remainder discarded.
- REQ-024: sub: a negative difference is stored as magnitude with a sign flag.
- REQ-025: div with B = 0: skip FORMAT and enter ERROR after the first COMPUTE cycle.
- REQ-026: FORMAT: double-dabble binary-to-BCD conversion; exactly BIN_W cycles; then RESULT.
- REQ-027: Latency: ex_strobe sampled at edge t -> busy high from t+1; RESULT entered at t+1+DIGITS+C+BIN_W, where C = 1 (add/sub/mul) or BIN_W (div). Defaults: 24 busy cycles for add, 43 for div.
- REQ-028: RESULT + dig_strobe: clears A and B, starts A with that digit, enters ENTER_A. op_strobe and bksp_strobe are ignored in RESULT.
- REQ-029: ERROR: only clr_strobe exits; disp_bcd = 0, disp_neg = 0.
- REQ-030: ms_strobe acts only in RESULT: stores result BCD and sign, sets mem_valid.
- REQ-031: mr_strobe acts only in ENTER_A/ENTER_B, and only if mem_valid, sign positive and the upper DIGITS digits are zero. It loads the low DIGITS digits into the active operand and sets the count to its significant digits; otherwise it is ignored.
- REQ-032: mc_strobe clears mem_valid and memory contents in any non-busy state.
- REQ-033: Display: ENTER_A shows A and ENTER_B shows B, each zero-extended with disp_neg = 0. Busy states hold the previous display. RESULT shows the result.

Reset
- REQ-034: reset_n low: immediate ENTER_A; A, B, counts, operator, result and memory = 0; disp_bcd = 0, disp_neg = 0, disp_sel = 00, busy = 0, err = 0, mem_valid = 0.
- REQ-035: Reset asserted mid-operation SHALL abort any conversion or division with no residual state.

Verification
- REQ-036: 1,2,+,3,4,5,ex -> busy 24 cycles, then disp_sel = 10, disp_bcd = 000357, disp_neg = 0.
- REQ-037: 5,-,1,2,ex -> disp_bcd = 000007, disp_neg = 1. 9,9,9,*,9,9,9,ex -> 998001.
- REQ-038: 1,0,0,/,7,ex -> 000014 after 43 busy cycles. 1,0,0,/,0,ex -> err = 1, disp_sel = 11; clr -> ENTER_A.
- REQ-039: 1,2,3,4 -> A = 123 (4th digit ignored); bksp twice -> A = 1; bksp on empty -> no change.
- REQ-040: 4,2,+,1,ex then ms -> mem_valid = 1. Then dig 7 (new entry), +, mr -> B = 43. Result 998001 stored, mr -> ignored.
- REQ-041: reset_n low during div COMPUTE -> all outputs at reset values; a following 6,/,3,ex -> 000002.
